filt_ppd_sched: RTL and testbench

Control sequencer for a time-multiplexed polyphase decimation FIR. It steers each incoming sample into its polyphase branch using a commutator phase counter, with CW or CCW rotation. After every gp_decimation_factor accepted samples it runs one L-cycle MAC sequence on a single shared multiply-accumulate unit, and it generates the decimated output strobe and slow clock. The block sits between the input sample interface and the branch delay-line, coefficient ROM and mul_add datapath of filt_ppd.

---
 rtl/filt_ppd_sched.sv | 143 ++++++++++++++
 tb/tb_filt_ppd_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filt_ppd_sched.sv
// Control sequencer for a time-multiplexed polyphase decimation FIR.
// Steers accepted samples to their polyphase branch through a commutator,
// runs one L-cycle MAC sequence per completed frame of M samples, and
// produces the decimated output strobe and slow clock.
module filt_ppd_sched #(
  parameter int gp_decimation_factor = 4,
  parameter int gp_coeff_length      = 16,
  parameter int gp_comm_ccw          = 1,
  parameter int gp_comm_phase        = 0,
  parameter int gp_phase_w           = 2,
  parameter int gp_caddr_w           = 4,
  parameter int gp_tap_w             = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_an,
  input  logic                  i_ena,
  input  logic                  i_valid,
  output logic                  o_wr_en,
  output logic [gp_phase_w-1:0] o_wr_phase,
  output logic                  o_mac_en,
  output logic                  o_mac_clr,
  output logic [gp_caddr_w-1:0] o_coeff_addr,
  output logic [gp_phase_w-1:0] o_phase_sel,
  output logic [gp_tap_w-1:0]   o_tap_sel,
  output logic                  o_out_stb,
  output logic                  o_sclk,
  output logic                  o_busy,
  output logic                  o_overrun
);

  localparam logic [gp_phase_w-1:0] PH_MAX   = gp_phase_w'(gp_decimation_factor - 1);
  localparam logic [gp_phase_w-1:0] PH_INIT  = gp_phase_w'(gp_comm_phase);
  localparam logic [gp_phase_w-1:0] FC_HALF  = gp_phase_w'(gp_decimation_factor / 2);
  localparam logic [gp_caddr_w-1:0] C_LAST   = gp_caddr_w'(gp_coeff_length - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [gp_caddr_w-1:0]   c_q;
  logic [gp_phase_w-1:0]   wc_q;
  logic [gp_phase_w-1:0]   wc_d;
  logic [gp_phase_w-1:0]   fc_q;
  logic [gp_phase_w-1:0]   fc_d;
  logic                    wr_en_q;
  logic [gp_phase_w-1:0]   wr_phase_q;
  logic                    sclk_q;
  logic                    overrun_q;
  logic                    accept;
  logic                    frame_done;

  assign accept     = i_ena & i_valid;
  assign frame_done = accept && (fc_q == PH_MAX);

  // Next commutator position and frame count for an accepted sample
  always_comb begin
    wc_d = wc_q;
    fc_d = fc_q;
    if (gp_comm_ccw != 0) begin
      wc_d = (wc_q == '0) ? PH_MAX : wc_q - 1'b1;
    end else begin
      wc_d = (wc_q == PH_MAX) ? '0 : wc_q + 1'b1;
    end
    fc_d = (fc_q == PH_MAX) ? '0 : fc_q + 1'b1;
  end

  // Input side: branch write strobe, commutator, frame counter, slow clock, overrun flag
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      wr_en_q    <= 1'b0;
      wr_phase_q <= '0;
      wc_q       <= PH_INIT;
      fc_q       <= '0;
      sclk_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (i_ena) begin
      wr_en_q <= i_valid;
      if (i_valid) begin
        wr_phase_q <= wc_q;
        wc_q       <= wc_d;
        fc_q       <= fc_d;
        if (frame_done) begin
          sclk_q <= 1'b1;
          // A frame landing while a sequence is still running is lost
          if (state_q != ST_IDLE) begin
            overrun_q <= 1'b1;
          end
        end else if (fc_d == FC_HALF) begin
          sclk_q <= 1'b0;
        end
      end
    end
  end

  // MAC sequencer: IDLE -> MAC (L cycles) -> DONE (one strobe cycle) -> IDLE
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
    end else if (i_ena) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_done) begin
            state_q <= ST_MAC;
            c_q     <= '0;
          end
        end
        ST_MAC: begin
          if (c_q == C_LAST) begin
            state_q <= ST_DONE;
            c_q     <= '0;
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          c_q     <= '0;
        end
      endcase
    end
  end

  // Strobes are masked while disabled so a stalled cycle never acts on the datapath
  assign o_wr_en      = wr_en_q & i_ena;
  assign o_wr_phase   = wr_phase_q;
  assign o_mac_en     = (state_q == ST_MAC) & i_ena;
  assign o_mac_clr    = o_mac_en & (c_q == '0);
  assign o_out_stb    = (state_q == ST_DONE) & i_ena;
  assign o_coeff_addr = c_q;
  assign o_phase_sel  = gp_phase_w'(int'(c_q) % gp_decimation_factor);
  assign o_tap_sel    = gp_tap_w'(int'(c_q) / gp_decimation_factor);
  assign o_sclk       = sclk_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_filt_ppd_sched.sv
// Self-checking bench for filt_ppd_sched: write-phase and output-strobe
// scoreboards, a MAC address monitor, and hand sequences for stall,
// overrun and mid-sequence reset.
module tb_filt_ppd_sched;

  localparam int M = 4;
  localparam int L = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic valid;
  logic valid_b;
  logic ena_b;

  logic       wr_en, mac_en, mac_clr, out_stb, sclk, busy, overrun;
  logic [1:0] wr_phase, phase_sel, tap_sel;
  logic [3:0] coeff_addr;

  logic       wr_en_b, mac_en_b, mac_clr_b, out_stb_b, sclk_b, busy_b, overrun_b;
  logic [1:0] wr_phase_b, phase_sel_b, tap_sel_b;
  logic [3:0] coeff_addr_b;

  filt_ppd_sched #(
    .gp_decimation_factor(M), .gp_coeff_length(L), .gp_comm_ccw(1), .gp_comm_phase(0),
    .gp_phase_w(2), .gp_caddr_w(4), .gp_tap_w(2)
  ) u_dut (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_valid(valid),
    .o_wr_en(wr_en), .o_wr_phase(wr_phase), .o_mac_en(mac_en), .o_mac_clr(mac_clr),
    .o_coeff_addr(coeff_addr), .o_phase_sel(phase_sel), .o_tap_sel(tap_sel),
    .o_out_stb(out_stb), .o_sclk(sclk), .o_busy(busy), .o_overrun(overrun)
  );

  filt_ppd_sched #(
    .gp_decimation_factor(M), .gp_coeff_length(L), .gp_comm_ccw(0), .gp_comm_phase(2),
    .gp_phase_w(2), .gp_caddr_w(4), .gp_tap_w(2)
  ) u_cw (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena_b), .i_valid(valid_b),
    .o_wr_en(wr_en_b), .o_wr_phase(wr_phase_b), .o_mac_en(mac_en_b), .o_mac_clr(mac_clr_b),
    .o_coeff_addr(coeff_addr_b), .o_phase_sel(phase_sel_b), .o_tap_sel(tap_sel_b),
    .o_out_stb(out_stb_b), .o_sclk(sclk_b), .o_busy(busy_b), .o_overrun(overrun_b)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int total = 0;
  int bad   = 0;

  // scoreboards
  int wr_q[$];
  int stb_q[$];
  int busy_q[$];

  // reference model of the input side
  int m_wc, m_fc, m_sclk, m_ovr, m_done_edge;
  int exp_c;
  int busy_run;

  typedef struct {
    int gap;
    int exp_ph;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One accept; exp_ph < 0 takes the expected branch from the model
  task automatic accept(input int exp_ph);
    int e;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    e = edge_cnt;
    wr_q.push_back((exp_ph < 0) ? m_wc : exp_ph);
    m_wc = (m_wc == 0) ? M - 1 : m_wc - 1;
    if (m_fc == M - 1) begin
      m_fc   = 0;
      m_sclk = 1;
      if (e <= m_done_edge) begin
        m_ovr = 1;
      end else begin
        m_done_edge = e + L + 1;
        stb_q.push_back(e + L);
        busy_q.push_back(L + 1);
      end
    end else begin
      m_fc++;
      if (m_fc == M / 2) m_sclk = 0;
    end
    check("sclk", int'(sclk), m_sclk);
    check("overrun", int'(overrun), m_ovr);
  endtask

  task automatic model_reset();
    m_wc = 0; m_fc = 0; m_sclk = 0; m_ovr = 0; m_done_edge = -100;
    exp_c = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_wr_phase"}, int'(wr_phase), 0);
    check({tag, "_mac_en"}, int'(mac_en), 0);
    check({tag, "_mac_clr"}, int'(mac_clr), 0);
    check({tag, "_coeff_addr"}, int'(coeff_addr), 0);
    check({tag, "_out_stb"}, int'(out_stb), 0);
    check({tag, "_sclk"}, int'(sclk), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  // Output monitor: pops scoreboards on DUT events, tracks the MAC address walk
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (wr_q.size() == 0) check("wr_unexpected", int'(wr_en), 0);
        else check("wr_phase", int'(wr_phase), wr_q.pop_front());
      end
      if (mac_en) begin
        check("coeff_addr", int'(coeff_addr), exp_c);
        check("phase_sel", int'(phase_sel), exp_c % M);
        check("tap_sel", int'(tap_sel), exp_c / M);
        check("mac_clr", int'(mac_clr), (exp_c == 0) ? 1 : 0);
        exp_c++;
      end
      if (busy) busy_run++;
      else busy_run = 0;
      if (out_stb) begin
        if (stb_q.size() == 0) begin
          check("stb_unexpected", int'(out_stb), 0);
        end else begin
          check("stb_edge", edge_cnt, stb_q.pop_front());
          check("busy_len", busy_run, busy_q.pop_front());
          check("mac_cycles", exp_c, L);
        end
        exp_c = 0;
      end
    end else begin
      busy_run = 0;
    end
  end

  vec_t t1[8];
  int   cw_tab[4];

  initial begin
    t1[0] = '{19, 0}; t1[1] = '{19, 3}; t1[2] = '{19, 2}; t1[3] = '{19, 1};
    t1[4] = '{19, 0}; t1[5] = '{19, 3}; t1[6] = '{19, 2}; t1[7] = '{19, 1};
    cw_tab[0] = 2; cw_tab[1] = 3; cw_tab[2] = 0; cw_tab[3] = 1;

    rst_n = 1'b0; ena = 1'b1; valid = 1'b0; valid_b = 1'b0; ena_b = 1'b1;
    busy_run = 0;
    model_reset();

    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);

    // CW commutator starting at phase 2
    for (int i = 0; i < 4; i++) begin
      valid_b = 1'b1;
      @(posedge clk);
      #1;
      valid_b = 1'b0;
      check("cw_wr_en", int'(wr_en_b), 1);
      check("cw_wr_phase", int'(wr_phase_b), cw_tab[i]);
      tick(1);
    end
    tick(25);

    // CCW: eight accepts spaced 20 cycles, two MAC bursts
    for (int i = 0; i < 8; i++) begin
      accept(t1[i].exp_ph);
      tick(t1[i].gap);
    end
    tick(25);

    // Stall: enable low for 5 cycles while c = 7
    for (int i = 0; i < 4; i++) begin
      accept(-1);
      if (i < 3) tick(2);
    end
    tick(7);
    ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_mac_en", int'(mac_en), 0);
      check("stall_addr", int'(coeff_addr), 7);
      check("stall_busy", int'(busy), 1);
      @(posedge clk);
      #1;
    end
    ena = 1'b1;
    stb_q[stb_q.size() - 1]   = stb_q[stb_q.size() - 1] + 5;
    busy_q[busy_q.size() - 1] = busy_q[busy_q.size() - 1] + 5;
    m_done_edge += 5;
    tick(25);

    // Back-to-back accepts: second frame complete overruns
    for (int i = 0; i < 8; i++) accept(-1);
    tick(30);
    check("overrun_sticky", int'(overrun), 1);

    // Reset in the middle of a burst at c = 9
    for (int i = 0; i < 4; i++) begin
      accept(-1);
      if (i < 3) tick(2);
    end
    tick(9);
    check("pre_reset_addr", int'(coeff_addr), 9);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    wr_q.delete();
    stb_q.delete();
    busy_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_reset_sclk", int'(sclk), 0);
    check("post_reset_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      accept(-1);
      tick(1);
    end
    tick(30);

    check("wr_pending", wr_q.size(), 0);
    check("stb_pending", stb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
